irq_ctrl: RTL and testbench

- Parametrised interrupt controller for the 8-bit-bus CPU family; it replaces the fixed three-input, toggle-detect interrupt logic inside the core.
- Features: N synchronised IRQ channels, per-channel mask and trigger mode, fixed priority, and a latched vector.
- Uses a REQ/ACK/EOI handshake with the CPU, plus a small memory-mapped register window for software control.

---
 rtl/irq_ctrl.sv | 145 ++++++++++++++
 tb/tb_irq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Parametrised interrupt controller: synchronised IRQ channels with per-channel mask and
// trigger mode, fixed lowest-index priority, REQ/ACK/EOI CPU handshake and a register window.
module irq_ctrl #(
   parameter int N_IRQ    = 3,
   parameter int ADDR_W   = 16,
   parameter int VEC_BASE = 2,
   parameter int VEC_STEP = 2
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic [N_IRQ-1:0]  IRQ_IN,
   input  logic              I_IEN,
   output logic              O_REQ,
   output logic [ADDR_W-1:0] O_VECTOR,
   input  logic              I_ACK,
   input  logic              I_EOI,
   input  logic              I_CS,
   input  logic              I_WREN,
   input  logic [1:0]        I_REG,
   input  logic [7:0]        I_DATA,
   output logic [7:0]        O_DATA
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

   state_t            state;
   logic [N_IRQ-1:0]  sync1, sync2, prev, mask, pending, mode;
   logic [1:0]        prime_cnt;
   logic [2:0]        grant;

   logic              wr_en;
   logic              grant_live;
   logic              unused_data;
   logic [N_IRQ-1:0]  wr_bits, reprime, events, grant_oh, ack_clr, sw_clr;
   logic [N_IRQ-1:0]  pending_nxt, eligible;
   logic [2:0]        winner;
   logic [ADDR_W-1:0] win_vector;
   logic [7:0]        rdata;

   assign wr_en       = I_CS & I_WREN;
   assign wr_bits     = I_DATA[N_IRQ-1:0];
   assign unused_data = ^I_DATA;
   assign reprime     = (wr_en && I_REG == 2'd2) ? (wr_bits ^ mode) : '0;
   assign sw_clr      = (wr_en && I_REG == 2'd1) ? wr_bits : '0;
   assign eligible    = pending & mask;

   // Events are suppressed while priming and on channels whose mode is being rewritten.
   always_comb begin
      events = '0;
      if (prime_cnt == 2'd0) begin
         for (int i = 0; i < N_IRQ; i++)
            events[i] = mode[i] ? (sync2[i] ^ prev[i]) : sync2[i];
      end
      events = events & ~reprime;
   end

   always_comb begin
      grant_oh = '0;
      for (int i = 0; i < N_IRQ; i++)
         grant_oh[i] = (grant == 3'(i));
   end

   assign grant_live  = |(mask & grant_oh);
   assign ack_clr     = (state == REQ && I_ACK) ? grant_oh : '0;
   // A set event in the same cycle as a clear keeps the bit set.
   assign pending_nxt = (pending & ~(ack_clr | sw_clr)) | events;

   always_comb begin
      winner = '0;
      for (int i = N_IRQ - 1; i >= 0; i--)
         if (eligible[i]) winner = 3'(i);
   end

   assign win_vector = ADDR_W'(VEC_BASE) + ADDR_W'(winner) * ADDR_W'(VEC_STEP);

   always_comb begin
      rdata = '0;
      case (I_REG)
         2'd0:    rdata[N_IRQ-1:0] = mask;
         2'd1:    rdata[N_IRQ-1:0] = pending;
         2'd2:    rdata[N_IRQ-1:0] = mode;
         default: rdata = {state, 3'b000, grant};
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state     <= IDLE;
         sync1     <= '0;
         sync2     <= '0;
         prev      <= '0;
         mask      <= '0;
         pending   <= '0;
         mode      <= '1;
         prime_cnt <= 2'd3;
         grant     <= '0;
         O_REQ     <= 1'b0;
         O_VECTOR  <= '0;
         O_DATA    <= '0;
      end else begin
         sync1   <= IRQ_IN;
         sync2   <= sync1;
         prev    <= sync2;
         pending <= pending_nxt;
         if (prime_cnt != 2'd0)
            prime_cnt <= prime_cnt - 2'd1;
         if (wr_en && I_REG == 2'd0)
            mask <= wr_bits;
         if (wr_en && I_REG == 2'd2)
            mode <= wr_bits;
         if (I_CS)
            O_DATA <= rdata;

         // Grant and vector stay frozen from REQ entry until the handshake completes.
         case (state)
            IDLE: begin
               if (eligible != '0 && I_IEN) begin
                  state    <= REQ;
                  grant    <= winner;
                  O_REQ    <= 1'b1;
                  O_VECTOR <= win_vector;
               end
            end
            REQ: begin
               if (I_ACK) begin
                  state <= SERVICE;
                  O_REQ <= 1'b0;
               end else if (!grant_live || !I_IEN) begin
                  state <= IDLE;
                  O_REQ <= 1'b0;
               end
            end
            SERVICE: begin
               if (I_EOI)
                  state <= IDLE;
            end
            default: begin
               state <= IDLE;
               O_REQ <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected vectors and register reads,
// a negedge monitor pops and compares whenever O_REQ rises or read data becomes valid.
module tb_irq_ctrl;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic [2:0]  IRQ_IN;
   logic        I_IEN, I_ACK, I_EOI, I_CS, I_WREN;
   logic [1:0]  I_REG;
   logic [7:0]  I_DATA;
   logic        O_REQ;
   logic [15:0] O_VECTOR;
   logic [7:0]  O_DATA;

   typedef struct {
      string       name;
      logic [15:0] val;
   } exp_t;

   exp_t vec_q[$];
   exp_t rd_q[$];
   exp_t cur;
   int   errors = 0;
   int   checks = 0;
   logic rd_valid = 1'b0;
   logic req_seen = 1'b0;

   irq_ctrl #(.N_IRQ(3), .ADDR_W(16), .VEC_BASE(2), .VEC_STEP(2)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .IRQ_IN(IRQ_IN), .I_IEN(I_IEN),
      .O_REQ(O_REQ), .O_VECTOR(O_VECTOR), .I_ACK(I_ACK), .I_EOI(I_EOI),
      .I_CS(I_CS), .I_WREN(I_WREN), .I_REG(I_REG), .I_DATA(I_DATA), .O_DATA(O_DATA)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] irq, input int cycles);
      IRQ_IN = irq;
      tick(cycles);
   endtask

   task automatic writeReg(input logic [1:0] idx, input logic [7:0] data);
      I_CS = 1'b1; I_WREN = 1'b1; I_REG = idx; I_DATA = data;
      tick(1);
      I_CS = 1'b0; I_WREN = 1'b0;
   endtask

   task automatic readReg(input logic [1:0] idx, input logic [7:0] expected, input string name);
      rd_q.push_back('{name, {8'h00, expected}});
      I_CS = 1'b1; I_WREN = 1'b0; I_REG = idx;
      tick(1);
      I_CS = 1'b0;
   endtask

   task automatic pulseAck();
      I_ACK = 1'b1;
      tick(1);
      I_ACK = 1'b0;
   endtask

   task automatic pulseEoi();
      I_EOI = 1'b1;
      tick(1);
      I_EOI = 1'b0;
   endtask

   task automatic waitReq(input string name);
      int n = 0;
      while (!O_REQ && n < 20) begin
         tick(1);
         n++;
      end
      checkOutput(name, {15'h0, O_REQ}, 16'h0001);
   endtask

   always @(posedge CLOCK)
      rd_valid <= I_CS && !I_WREN && !RESET;

   // Monitor: compare against the oldest queued expectation whenever the DUT presents output.
   always @(negedge CLOCK) begin
      if (rd_valid) begin
         if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected read: got %h, expected no read", O_DATA);
         end else begin
            cur = rd_q.pop_front();
            checkOutput(cur.name, {8'h00, O_DATA}, cur.val);
         end
      end
      if (O_REQ && !req_seen) begin
         if (vec_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected request: got vector %h, expected no request", O_VECTOR);
         end else begin
            cur = vec_q.pop_front();
            checkOutput(cur.name, O_VECTOR, cur.val);
         end
      end
      req_seen = O_REQ;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      RESET = 1'b1; IRQ_IN = 3'b111; I_IEN = 1'b0; I_ACK = 1'b0; I_EOI = 1'b0;
      I_CS = 1'b0; I_WREN = 1'b0; I_REG = 2'd0; I_DATA = 8'h00;
      tick(1);
      checkOutput("reset O_REQ", {15'h0, O_REQ}, 16'h0000);
      checkOutput("reset O_VECTOR", O_VECTOR, 16'h0000);
      checkOutput("reset O_DATA", {8'h00, O_DATA}, 16'h0000);
      tick(1);
      RESET = 1'b0;

      // Inputs held high through reset must not produce events.
      tick(10);
      checkOutput("primed O_REQ", {15'h0, O_REQ}, 16'h0000);
      readReg(2'd1, 8'h00, "primed PENDING");
      readReg(2'd2, 8'h07, "reset MODE");
      readReg(2'd0, 8'h00, "reset MASK");
      readReg(2'd3, 8'h00, "reset STATUS");

      // Toggle channel 1.
      writeReg(2'd0, 8'h07);
      I_IEN = 1'b1;
      vec_q.push_back('{"ch1 vector", 16'h0004});
      applyStimulus(3'b101, 3);
      readReg(2'd1, 8'h02, "ch1 PENDING");
      waitReq("ch1 O_REQ");
      pulseAck();
      checkOutput("ack drops O_REQ", {15'h0, O_REQ}, 16'h0000);
      readReg(2'd3, 8'h81, "STATUS ch1 service");
      pulseEoi();
      readReg(2'd1, 8'h00, "PENDING after ack");

      // Simultaneous toggles on channels 0 and 2: lowest index first.
      vec_q.push_back('{"ch0 first vector", 16'h0002});
      vec_q.push_back('{"ch2 second vector", 16'h0006});
      applyStimulus(3'b000, 1);
      waitReq("ch0 O_REQ");
      pulseAck();
      tick(2);
      checkOutput("no nesting", {15'h0, O_REQ}, 16'h0000);
      readReg(2'd3, 8'h80, "STATUS ch0 service");
      pulseEoi();
      waitReq("ch2 O_REQ after EOI");
      pulseAck();
      pulseEoi();

      // Re-trigger channel 0 while it is in service.
      vec_q.push_back('{"ch0 vector", 16'h0002});
      vec_q.push_back('{"ch0 vector after EOI", 16'h0002});
      applyStimulus(3'b001, 1);
      waitReq("ch0 O_REQ");
      pulseAck();
      applyStimulus(3'b000, 6);
      checkOutput("held during service", {15'h0, O_REQ}, 16'h0000);
      readReg(2'd1, 8'h01, "re-pend during service");
      pulseEoi();
      waitReq("ch0 O_REQ after EOI");
      pulseAck();
      pulseEoi();

      // Level mode on channel 1.
      writeReg(2'd2, 8'h05);
      vec_q.push_back('{"level ch1 vector", 16'h0004});
      applyStimulus(3'b010, 1);
      waitReq("level ch1 O_REQ");
      writeReg(2'd1, 8'h02);
      readReg(2'd1, 8'h02, "level set beats clear");
      writeReg(2'd0, 8'h05);
      tick(1);
      checkOutput("mask clear drops O_REQ", {15'h0, O_REQ}, 16'h0000);
      readReg(2'd3, 8'h01, "STATUS idle after abort");
      readReg(2'd1, 8'h02, "PENDING kept after abort");
      pulseAck();
      pulseEoi();
      readReg(2'd3, 8'h01, "stray ACK/EOI ignored");

      // Reset in the middle of a request.
      vec_q.push_back('{"ch1 vector before reset", 16'h0004});
      writeReg(2'd0, 8'h07);
      waitReq("O_REQ before reset");
      RESET = 1'b1;
      tick(1);
      checkOutput("mid-req reset O_REQ", {15'h0, O_REQ}, 16'h0000);
      checkOutput("mid-req reset O_VECTOR", O_VECTOR, 16'h0000);
      checkOutput("mid-req reset O_DATA", {8'h00, O_DATA}, 16'h0000);
      RESET = 1'b0;
      readReg(2'd0, 8'h00, "MASK after reset");
      readReg(2'd3, 8'h00, "STATUS after reset");

      tick(4);
      checkOutput("vector queue drained", 16'(vec_q.size()), 16'h0000);
      checkOutput("read queue drained", 16'(rd_q.size()), 16'h0000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
